mem_arbiter: RTL and testbench

Sequencing arbiter that shares one single-port 16-bit byte-addressable memory between the instruction-fetch port and the data (load/store) port of the processor. It inserts a programmable number of wait states per access to model slower memory, and guarantees exactly one memory write per store. It rejects misaligned addresses without touching memory and holds each requester in a stall until its access completes. It sits between the fetch/memory pipeline stages and the memory instance.

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the processor's fetch/data ports, the
// arbiter and the single-port memory.
//   slave  : arbiter view (takes requests + mem read data, drives completions
//            and the memory control/address/write-data lines)
//   master : requester/memory view (the opposite directions)
// Fetch port : if_req, if_addr -> if_rdata, if_done, if_err, if_stall
// Data port  : d_req, d_wr, d_addr, d_wdata -> d_rdata, d_done, d_err, d_stall
// Memory port: mem_enable, mem_wr, mem_addr, mem_wdata <- mem_rdata
interface mem_arbiter_if #(parameter int ADDR_WIDTH = 16);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [15:0]           if_rdata;
  logic                  if_done;
  logic                  if_err;
  logic                  if_stall;

  logic                  d_req;
  logic                  d_wr;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [15:0]           d_wdata;
  logic [15:0]           d_rdata;
  logic                  d_done;
  logic                  d_err;
  logic                  d_stall;

  logic                  mem_enable;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic [15:0]           mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_done, if_err, if_stall,
           d_rdata, d_done, d_err, d_stall,
           mem_enable, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_done, if_err, if_stall,
           d_rdata, d_done, d_err, d_stall,
           mem_enable, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 16-bit byte-addressed memory between
// the instruction-fetch port and the data (load/store) port.
// Each grant walks IDLE -> WAIT (WAIT_CYCLES cycles) -> ACCESS (1 cycle) ->
// DONE (1 cycle). Misaligned addresses skip straight to DONE with err set and
// never enable the memory. Data normally wins arbitration; after STARVE_LIMIT
// consecutive data grants that overtook a waiting fetch, fetch is forced.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active high
//   bus  : mem_arbiter_if.slave (fetch port, data port, memory port)
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            wait_cnt;
  logic [3:0]            starve_cnt;
  logic                  own_d;     // 1 = current grant belongs to data port
  logic                  wr_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wdata_q;
  logic [15:0]           if_rdata_q;
  logic [15:0]           d_rdata_q;

  logic                  grant_any;
  logic                  grant_d;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic                  if_done_w, d_done_w;
  logic                  if_err_w, d_err_w;
  logic                  mem_en_w, mem_wr_w;

  assign grant_any  = bus.d_req | bus.if_req;
  // data wins unless a waiting fetch has been overtaken STARVE_LIMIT times
  assign grant_d    = bus.d_req & ~(bus.if_req & (starve_cnt == 4'(STARVE_LIMIT)));
  assign grant_addr = grant_d ? bus.d_addr : bus.if_addr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Completion and memory strobes are gated by rst so nothing fires while
  // reset is held, whatever the state register holds before its first edge.
  always_comb begin
    state_nxt = state;
    if_done_w = 1'b0;
    d_done_w  = 1'b0;
    if_err_w  = 1'b0;
    d_err_w   = 1'b0;
    mem_en_w  = 1'b0;
    mem_wr_w  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          if (grant_addr[0])         state_nxt = DONE;
          else if (WAIT_CYCLES == 0) state_nxt = ACCESS;
          else                       state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd1) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_en_w  = ~rst;
        mem_wr_w  = ~rst & wr_q;
        state_nxt = DONE;
      end
      DONE: begin
        if_done_w = ~rst & ~own_d;
        d_done_w  = ~rst & own_d;
        if_err_w  = ~rst & ~own_d & err_q;
        d_err_w   = ~rst & own_d & err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      starve_cnt <= '0;
      own_d      <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            own_d    <= grant_d;
            addr_q   <= grant_addr;
            wr_q     <= grant_d & bus.d_wr;
            err_q    <= grant_addr[0];
            wait_cnt <= 4'(WAIT_CYCLES);
            if (grant_d) wdata_q <= bus.d_wdata;
            if (grant_d & bus.if_req)
              starve_cnt <= (starve_cnt == 4'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 4'd1;
            else
              starve_cnt <= '0;
          end
        end
        WAIT: wait_cnt <= wait_cnt - 4'd1;
        ACCESS: begin
          // read data is combinational from the memory; capture on the closing edge
          if (!wr_q) begin
            if (own_d) d_rdata_q  <= bus.mem_rdata;
            else       if_rdata_q <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.if_done    = if_done_w;
  assign bus.d_done     = d_done_w;
  assign bus.if_err     = if_err_w;
  assign bus.d_err      = d_err_w;
  assign bus.if_stall   = bus.if_req & ~if_done_w;
  assign bus.d_stall    = bus.d_req & ~d_done_w;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.mem_enable = mem_en_w;
  assign bus.mem_wr     = mem_wr_w;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized fetch/data traffic.
// A transaction-level reference (request queues, grant timeline, shadow
// memory) predicts completions, strobes and read data cycle by cycle.
module tb_mem_arbiter;
  localparam int AW   = 16;
  localparam int WC   = 2;
  localparam int SLIM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC), .STARVE_LIMIT(SLIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- memory behind the arbiter ----------------
  function automatic logic [15:0] seed(int i);
    if (i == 8) return 16'hBEEF;
    return 16'(i * 40503 + 4369);
  endfunction

  logic [15:0] ram [0:127];
  bit          seeded = 1'b0;
  int          wr_pulses = 0;
  int          en_pulses = 0;

  assign bus.mem_rdata = ram[bus.mem_addr[7:1]];

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 128; i++) ram[i] <= seed(i);
      seeded <= 1'b1;
    end else if (bus.mem_enable && bus.mem_wr) begin
      ram[bus.mem_addr[7:1]] <= bus.mem_wdata;
    end
    if (bus.mem_enable) en_pulses <= en_pulses + 1;
    if (bus.mem_enable && bus.mem_wr) wr_pulses <= wr_pulses + 1;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int fails  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          gap;
  } op_t;

  op_t fq[$], dq[$];
  op_t f_cur, d_cur, g;
  bit  f_act, d_act, busy, own_d;
  int  cyc, idle_at, acc_at, done_at, f_issue, d_issue;
  int  overtakes;          // data grants in a row that jumped a waiting fetch
  logic [15:0] ref_mem [0:127];
  logic [15:0] e_if_rdata, e_d_rdata;

  // observations of the DUT for directed timing checks
  int f_lat_obs, d_lat_obs, n_dd_obs, n_dd_at_ifd;
  logic d_err_obs;

  // One clock cycle; entered and left at a negedge.
  task automatic step();
    bit e_ifd, e_dd, e_err, e_en, e_wr;
    e_ifd = busy && cyc == done_at && !own_d;
    e_dd  = busy && cyc == done_at && own_d;
    e_err = g.addr[0];
    e_en  = busy && cyc == acc_at;
    e_wr  = e_en && own_d && g.wr;
    if ((e_ifd || e_dd) && !e_err) begin
      if (own_d && g.wr)  ref_mem[g.addr[7:1]] = g.wdata;
      else if (own_d)     e_d_rdata  = ref_mem[g.addr[7:1]];
      else                e_if_rdata = ref_mem[g.addr[7:1]];
    end

    if (bus.d_done) n_dd_obs++;
    if (bus.d_done && d_act) begin d_lat_obs = cyc - d_issue; d_err_obs = bus.d_err; end
    if (bus.if_done && f_act) begin f_lat_obs = cyc - f_issue; n_dd_at_ifd = n_dd_obs; end

    chk("if_done",    32'(bus.if_done),    32'(e_ifd));
    chk("d_done",     32'(bus.d_done),     32'(e_dd));
    if (e_ifd) chk("if_err", 32'(bus.if_err), 32'(e_err));
    if (e_dd)  chk("d_err",  32'(bus.d_err),  32'(e_err));
    chk("mem_enable", 32'(bus.mem_enable), 32'(e_en));
    chk("mem_wr",     32'(bus.mem_wr),     32'(e_wr));
    if (e_en) chk("mem_addr", 32'(bus.mem_addr), 32'(g.addr));
    if (e_wr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(g.wdata));
    chk("if_rdata",   32'(bus.if_rdata),   32'(e_if_rdata));
    chk("d_rdata",    32'(bus.d_rdata),    32'(e_d_rdata));
    chk("if_stall",   32'(bus.if_stall),   32'(f_act && !e_ifd));
    chk("d_stall",    32'(bus.d_stall),    32'(d_act && !e_dd));

    if (e_ifd) begin f_act = 0; busy = 0; end
    if (e_dd)  begin d_act = 0; busy = 0; end

    if (!f_act && fq.size() > 0) begin
      if (fq[0].gap > 0) fq[0].gap = fq[0].gap - 1;
      else begin f_cur = fq.pop_front(); f_act = 1; f_issue = cyc; end
    end
    if (!d_act && dq.size() > 0) begin
      if (dq[0].gap > 0) dq[0].gap = dq[0].gap - 1;
      else begin d_cur = dq.pop_front(); d_act = 1; d_issue = cyc; end
    end
    bus.if_req  = f_act;
    bus.if_addr = f_cur.addr;
    bus.d_req   = d_act;
    bus.d_wr    = d_cur.wr;
    bus.d_addr  = d_cur.addr;
    bus.d_wdata = d_cur.wdata;

    if (!busy && cyc >= idle_at && (f_act || d_act)) begin
      own_d = d_act && !(f_act && overtakes >= SLIM);
      g     = own_d ? d_cur : f_cur;
      if (!own_d) g.wr = 1'b0;
      overtakes = (own_d && f_act) ? overtakes + 1 : 0;
      busy = 1;
      if (g.addr[0]) begin done_at = cyc + 1; acc_at = -1; end
      else begin acc_at = cyc + WC + 1; done_at = cyc + WC + 2; end
      idle_at = done_at + 1;
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    bit done = 0;
    while (!done && n < 4000) begin
      done = fq.size() == 0 && dq.size() == 0 && !f_act && !d_act && !busy && cyc >= idle_at;
      if (!done) begin step(); n++; end
    end
    if (!done) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  function automatic op_t mk(logic wr, logic [15:0] addr, logic [15:0] wdata, int gap);
    op_t o;
    o.wr = wr; o.addr = addr; o.wdata = wdata; o.gap = gap;
    return o;
  endfunction

  int w0, e0, n0;
  logic [15:0] m0;

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = seed(i);
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_wr = 0; bus.d_addr = '0; bus.d_wdata = '0;
    f_cur = mk(0, 0, 0, 0); d_cur = mk(0, 0, 0, 0); g = mk(0, 0, 0, 0);
    f_act = 0; d_act = 0; busy = 0; own_d = 0; overtakes = 0;
    e_if_rdata = '0; e_d_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
    chk("rst_mem_wr",     32'(bus.mem_wr),     32'd0);
    chk("rst_if_done",    32'(bus.if_done),    32'd0);
    chk("rst_d_done",     32'(bus.d_done),     32'd0);
    chk("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    chk("rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
    chk("rst_if_rdata",   32'(bus.if_rdata),   32'd0);
    chk("rst_d_rdata",    32'(bus.d_rdata),    32'd0);
    rst = 1'b0;
    cyc = 0; idle_at = 0; acc_at = -1; done_at = -1;

    // fetch of 0x0010 alone
    fq.push_back(mk(0, 16'h0010, 0, 0));
    drain();
    chk("fetch_latency", 32'(f_lat_obs), 32'd4);
    chk("fetch_data",    32'(bus.if_rdata), 32'hBEEF);

    // store then load of the same word
    w0 = wr_pulses;
    dq.push_back(mk(1, 16'h0020, 16'h1234, 0));
    dq.push_back(mk(0, 16'h0020, 0, 0));
    drain();
    chk("store_one_write", 32'(wr_pulses - w0), 32'd1);
    chk("load_after_store", 32'(bus.d_rdata), 32'h1234);

    // misaligned load
    e0 = en_pulses;
    dq.push_back(mk(0, 16'h0021, 0, 0));
    drain();
    chk("misalign_latency", 32'(d_lat_obs), 32'd1);
    chk("misalign_err",     32'(d_err_obs), 32'd1);
    chk("misalign_no_mem",  32'(en_pulses - e0), 32'd0);
    chk("misalign_rdata",   32'(bus.d_rdata), 32'h1234);

    // simultaneous fetch and data
    fq.push_back(mk(0, 16'h0002, 0, 0));
    dq.push_back(mk(0, 16'h0004, 0, 0));
    drain();
    chk("simul_d_latency",  32'(d_lat_obs), 32'd4);
    chk("simul_if_latency", 32'(f_lat_obs), 32'd9);

    // data streaming while fetch waits: fetch goes after the 4th data grant
    n0 = n_dd_obs;
    fq.push_back(mk(0, 16'h0006, 0, 0));
    for (int i = 0; i < 6; i++) dq.push_back(mk(0, 16'(2 * i + 8), 0, 0));
    drain();
    chk("starve_order", 32'(n_dd_at_ifd - n0), 32'(SLIM));

    // randomized mixed traffic
    for (int i = 0; i < 150; i++) begin
      fq.push_back(mk(0, 16'($urandom_range(0, 31) * 2 + ($urandom_range(0, 7) == 0)),
                      0, $urandom_range(0, 4)));
      dq.push_back(mk(1'($urandom_range(0, 1)),
                      16'($urandom_range(0, 31) * 2 + ($urandom_range(0, 7) == 0)),
                      16'($urandom), $urandom_range(0, 3)));
    end
    drain();

    // reset while a store sits in WAIT
    w0 = wr_pulses;
    m0 = ram[32];
    bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h0040; bus.d_wdata = 16'h5A5A;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("midrst_mem_enable", 32'(bus.mem_enable), 32'd0);
    chk("midrst_d_done",     32'(bus.d_done),     32'd0);
    chk("midrst_mem_addr",   32'(bus.mem_addr),   32'd0);
    chk("midrst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
    chk("midrst_if_rdata",   32'(bus.if_rdata),   32'd0);
    chk("midrst_d_rdata",    32'(bus.d_rdata),    32'd0);
    bus.d_req = 0;
    @(posedge clk); @(negedge clk);
    chk("midrst_hold_enable", 32'(bus.mem_enable), 32'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_write", 32'(wr_pulses - w0), 32'd0);
    chk("midrst_mem_kept", 32'(ram[32]), 32'(seed(32)));
    chk("midrst_mem_same", 32'(ram[32]), 32'(m0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
